// File: rtl/seq_borrow_sub_pkg.sv
// Shared constants for seq_borrow_sub: FSM encodings, default geometry, counter sizing.
// Imported by the RTL and by the bench.
package seq_borrow_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // Slice counter width; a single-slice build still needs a 1-bit counter.
  function automatic int cnt_w(input int nsl);
    return (nsl <= 1) ? 1 : $clog2(nsl);
  endfunction

endpackage

// File: rtl/seq_borrow_sub_bla_slice.sv
// bla_slice: SLICE-bit borrow-lookahead subtractor, diff = x - y - bi; purely combinational.
// Each internal borrow is flattened from generate/propagate terms rather than rippled.
module bla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bi,
  output logic [SLICE-1:0] diff,
  output logic             bo
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   bw;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  always_comb begin
    logic acc;
    bw   = '0;
    diff = '0;
    bo   = 1'b0;
    acc  = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      acc = bi;
      for (int j = 0; j < i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      bw[i] = acc;
    end
    for (int i = 0; i < SLICE; i++) begin
      diff[i] = x[i] ^ y[i] ^ bw[i];
    end
    bo = bw[SLICE];
  end

endmodule

// File: rtl/seq_borrow_sub.sv
// Sequential subtractor d = a - b - bin, one SLICE chunk per clock; result after WIDTH/SLICE cycles,
// held under out_ready back-pressure. Define SEQ_SUB_OVF_EN to produce the signed overflow flag.
module seq_borrow_sub
  import seq_borrow_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = cnt_w(NSL);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] sl_x, sl_y, sl_diff;
  logic             sl_bo;

  // brw_q carries bin into slice 0 and each slice's borrow-out into the next.
  assign sl_x = a_q[cnt_q*SLICE +: SLICE];
  assign sl_y = b_q[cnt_q*SLICE +: SLICE];

  bla_slice #(.SLICE(SLICE)) u_slice (
    .x    (sl_x),
    .y    (sl_y),
    .bi   (brw_q),
    .diff (sl_diff),
    .bo   (sl_bo)
  );

`ifdef SEQ_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    brw_d       = brw_q;
    d_d         = d_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          brw_d      = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        d_d[cnt_q*SLICE +: SLICE] = sl_diff;
        brw_d = sl_bo;
        if (cnt_q == CW'(NSL - 1)) begin
          bout_d      = sl_bo;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef SEQ_SUB_OVF_EN
          ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_diff[SLICE-1] != a_q[WIDTH-1]);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      brw_q       <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      brw_q       <= brw_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SEQ_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_seq_borrow_sub.sv
// Directed bench for seq_borrow_sub: reference arithmetic feeds a result queue checked on out_valid.
module tb_seq_borrow_sub;
  import seq_borrow_sub_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int NSL = DEF_WIDTH / DEF_SLICE;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  seq_borrow_sub #(.WIDTH(DEF_WIDTH), .SLICE(DEF_SLICE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t r;
    logic [W:0] full;
    full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    r.d    = full[W-1:0];
    r.bout = full[W];
`ifdef SEQ_SUB_OVF_EN
    r.ovf  = ($signed(x) - $signed(y) - $signed({1'b0, bi})) != $signed(full[W-1:0]) ? 1'b1 :
             ((x[W-1] != y[W-1]) && (full[W-1] != x[W-1]));
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input int hold);
    res_t e;
    int   lat;
    wait_ready(tag);
    a = x; b = y; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(x, y, bi));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NSL));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_d"}, 32'(d), 32'(e.d));
    check({tag, "_bout"}, 32'(bout), 32'(e.bout));
    check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_d"}, 32'(d), 32'(e.d));
      check({tag, "_hold_bout"}, 32'(bout), 32'(e.bout));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    do_op("basic", 16'h1234, 16'h0234, 1'b0, 7);
    do_op("wrap_b1", 16'h0000, 16'h0001, 1'b0, 0);
    do_op("wrap_bin", 16'h0000, 16'h0000, 1'b1, 0);
    do_op("chain", 16'h1000, 16'h0001, 1'b0, 0);
    do_op("ovf_pos", 16'h8000, 16'h0001, 1'b0, 2);
    do_op("ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 0);
    do_op("bin_eq", 16'h5555, 16'h5554, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), i % 3);
    end

    wait_ready("midrst");
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_d", 32'(d), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();
    check("midrst_no_result", 32'(out_valid), 32'd0);
    do_op("after_rst", 16'h0005, 16'h0003, 1'b0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
